fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the instruction fetch queue. It issues line-aligned 128-bit read requests to the instruction cache, tracks outstanding requests against free queue slots with a credit scheme, and forwards returned lines to the queue. On a jump/branch redirect it flushes the queue and discards stale responses still in flight. It sits between the branch-resolution logic, the instruction cache and the fetch queue.

## Interface
- QUEUE_LINES, 4, line slots in the fetch queue (≤15)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered cache requests (≤7)
- RESET_PC, 32'h0040_0000, fetch start address after reset
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_redirect_valid  in  1  jump/branch redirect, single-cycle pulse
- i_redirect_addr  in  32  redirect target, word-aligned
- i_line_pop  in  1  queue released one line slot (last word of a line read)
- o_req_valid  out  1  cache read request
- o_req_addr  out  32  request address, bits [3:0] always 0
- i_req_ready  in  1  cache accepts request this cycle
- i_resp_valid  in  1  cache returns a line
- i_resp_data  in  128  returned line
- o_line_valid  out  1  write enable into queue
- o_line_data  out  128  line into queue (= i_resp_data)
- o_flush  out  1  queue flush
- o_flush_word  out  2  starting word in first line after flush
- o_abort  out  1  cancel pending request at cache

## Operation
- FSM states: IDLE, FETCH, STALL.
- IDLE: entered on reset, left unconditionally next cycle to FETCH.
- live = outstanding − drop_cnt; credit = QUEUE_LINES − occ − live.
- FETCH: o_req_valid=1. Accept = o_req_valid & i_req_ready: outstanding+1, o_req_addr += 16 (wraps modulo 2^32). Go to STALL when, after this cycle's updates, credit==0 or outstanding==MAX_OUTSTANDING.
- STALL: o_req_valid=0; return to FETCH when credit>0 and outstanding<MAX_OUTSTANDING.
- Response: outstanding−1. If drop_cnt>0, drop_cnt−1 and line discarded; else o_line_valid=1, occ+1.
- i_line_pop: occ−1; pop with occ==0 is ignored.
- Redirect (highest priority): o_flush=1, o_flush_word=i_redirect_addr[3:2], occ←0, drop_cnt←outstanding after this cycle's accept/response, o_req_addr←{i_redirect_addr[31:4],4'b0}, state←FETCH. A response in the same cycle is discarded (o_line_valid=0) and still decrements outstanding. A request accepted in the same cycle is counted stale. Concurrent i_line_pop ignored.
- o_abort=1 when redirect arrives with o_req_valid=1 & i_req_ready=0 (pending request withdrawn).
- Counters saturate: never exceed limits, never underflow; a response with outstanding==0 is a protocol error and is ignored.

## Timing
- Reset values: o_req_valid 0, o_req_addr RESET_PC&~15, o_line_valid 0, o_flush 0, o_flush_word 0, o_abort 0, occ/outstanding/drop_cnt 0, state IDLE.
- First request: o_req_valid=1 in 2nd cycle after reset release.
- o_req_valid, o_req_addr registered; held stable until accepted except on redirect.
- Response path combinational: o_line_valid same cycle as i_resp_valid.
- o_flush, o_flush_word, o_abort combinational, same cycle as i_redirect_valid.
- Redirect in cycle N: o_req_addr = new line address with o_req_valid=1 in N+1 (if credit permits).
- Back-to-back accepts allowed every cycle while credit and outstanding permit.

## Configuration
- FETCH_PERF_EN defined: adds outputs o_perf_lines[31:0] (lines forwarded), o_perf_drops[15:0] (stale responses discarded), o_perf_stall[31:0] (cycles in STALL); all reset to 0, wrap on overflow, cleared only by reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, i_req_ready=1, no responses -> requests at 0x0040_0000, 0x0040_0010, then STALL (outstanding=2).
- Responses one cycle after each accept, no pops -> exactly 4 lines forwarded, then STALL with occ=4; one i_line_pop -> one further request at 0x0040_0040.
- Two outstanding, redirect to 0x0000_1238 -> o_flush=1, o_flush_word=2; next cycle request at 0x0000_1230; next two responses dropped; third forwarded.
- Redirect coincident with response and pop -> o_line_valid=0, occ=0, outstanding decremented by one.
- i_req_ready=0 for 3 cycles then redirect -> o_abort=1, o_req_addr stable until redirect, then new address.
- Start at RESET_PC=32'hFFFF_FFF0 -> second request address 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues line-aligned cache reads under a queue-credit scheme and
// flushes/discards stale lines on redirect. Define FETCH_PERF_EN to add perf counters.
module fetch_ctrl #(
    parameter int unsigned QUEUE_LINES     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0040_0000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_redirect_valid,
    input  logic [31:0]  i_redirect_addr,
    input  logic         i_line_pop,
    output logic         o_req_valid,
    output logic [31:0]  o_req_addr,
    input  logic         i_req_ready,
    input  logic         i_resp_valid,
    input  logic [127:0] i_resp_data,
    output logic         o_line_valid,
    output logic [127:0] o_line_data,
    output logic         o_flush,
    output logic [1:0]   o_flush_word,
    output logic         o_abort
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  o_perf_lines,
    output logic [15:0]  o_perf_drops,
    output logic [31:0]  o_perf_stall
`endif
);

    localparam logic [3:0]  QL         = 4'(QUEUE_LINES);
    localparam logic [2:0]  MO         = 3'(MAX_OUTSTANDING);
    localparam logic [31:0] RESET_LINE = {RESET_PC[31:4], 4'h0};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  occ_q, occ_d;
    logic [2:0]  out_q, out_d;
    logic [2:0]  drop_q, drop_d;

    logic        accept;
    logic        resp_ok;
    logic        resp_fwd;
    logic        pop_ok;
    logic        can_fetch;
    logic [3:0]  out_sum;
    logic [4:0]  occ_sum;
    logic [2:0]  live_d;
    logic [4:0]  used_d;

    logic        unused_redirect_bits;
    assign unused_redirect_bits = ^i_redirect_addr[1:0];

    // Responses arriving with nothing outstanding are protocol errors and have no effect.
    assign o_req_valid = (state_q == FETCH);
    assign accept      = o_req_valid & i_req_ready;
    assign resp_ok     = i_resp_valid & (out_q != 3'd0);
    assign resp_fwd    = resp_ok & (drop_q == 3'd0) & ~i_redirect_valid;
    assign pop_ok      = i_line_pop & (occ_q != 4'd0);

    assign o_req_addr   = addr_q;
    assign o_line_valid = resp_fwd;
    assign o_line_data  = i_resp_data;
    assign o_flush      = i_redirect_valid;
    assign o_flush_word = i_redirect_valid ? i_redirect_addr[3:2] : 2'b00;
    assign o_abort      = i_redirect_valid & o_req_valid & ~i_req_ready;

    always_comb begin
        out_sum = {1'b0, out_q} + {3'b000, accept} - {3'b000, resp_ok};
        out_d   = (out_sum > {1'b0, MO}) ? MO : out_sum[2:0];

        occ_sum = {1'b0, occ_q} + {4'b0000, resp_fwd} - {4'b0000, pop_ok};
        occ_d   = (occ_sum > {1'b0, QL}) ? QL : occ_sum[3:0];

        drop_d = drop_q;
        if (resp_ok && (drop_q != 3'd0)) begin
            drop_d = drop_q - 3'd1;
        end

        addr_d = addr_q;
        if (accept) begin
            addr_d = addr_q + 32'd16;
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (i_redirect_valid) begin
            occ_d  = 4'd0;
            drop_d = out_d;
            addr_d = {i_redirect_addr[31:4], 4'h0};
        end

        live_d    = out_d - drop_d;
        used_d    = {1'b0, occ_d} + {2'b00, live_d};
        can_fetch = (used_d < {1'b0, QL}) && (out_d < MO);

        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = can_fetch ? FETCH : STALL;
            STALL:   state_d = can_fetch ? FETCH : STALL;
            default: state_d = IDLE;
        endcase
        if (i_redirect_valid) begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_LINE;
            occ_q   <= 4'd0;
            out_q   <= 3'd0;
            drop_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            occ_q   <= occ_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_lines_q;
    logic [15:0] perf_drops_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_lines_q <= 32'd0;
            perf_drops_q <= 16'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (resp_fwd) begin
                perf_lines_q <= perf_lines_q + 32'd1;
            end
            if (resp_ok && !resp_fwd) begin
                perf_drops_q <= perf_drops_q + 16'd1;
            end
            if (state_q == STALL) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign o_perf_lines = perf_lines_q;
    assign o_perf_drops = perf_drops_q;
    assign o_perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic against a
// counter-level reference model of the fetch queue, cache and redirect rules.
module tb_fetch_ctrl;

    localparam int QL = 4;
    localparam int MO = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         redirValid = 1'b0;
    logic [31:0]  redirAddr = '0;
    logic         linePop = 1'b0;
    logic         reqReady = 1'b0;
    logic         respValid = 1'b0;
    logic [127:0] respData = '0;

    logic         reqValid;
    logic [31:0]  reqAddr;
    logic         lineValid;
    logic [127:0] lineData;
    logic         flush;
    logic [1:0]   flushWord;
    logic         abortReq;

    logic         d2ReqValid;
    logic [31:0]  d2ReqAddr;
    logic         d2LineValid;
    logic [127:0] d2LineData;
    logic         d2Flush;
    logic [1:0]   d2FlushWord;
    logic         d2Abort;

    always #5 clk = ~clk;

    fetch_ctrl #(.QUEUE_LINES(QL), .MAX_OUTSTANDING(MO), .RESET_PC(32'h0040_0000)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_redirect_valid(redirValid), .i_redirect_addr(redirAddr),
        .i_line_pop(linePop),
        .o_req_valid(reqValid), .o_req_addr(reqAddr), .i_req_ready(reqReady),
        .i_resp_valid(respValid), .i_resp_data(respData),
        .o_line_valid(lineValid), .o_line_data(lineData),
        .o_flush(flush), .o_flush_word(flushWord), .o_abort(abortReq)
    );

    // Second instance starting at the top of the address space to exercise wrap-around.
    fetch_ctrl #(.QUEUE_LINES(QL), .MAX_OUTSTANDING(MO), .RESET_PC(32'hFFFF_FFF0)) dutWrap (
        .i_clk(clk), .i_rst(rst),
        .i_redirect_valid(1'b0), .i_redirect_addr(32'h0),
        .i_line_pop(1'b0),
        .o_req_valid(d2ReqValid), .o_req_addr(d2ReqAddr), .i_req_ready(1'b1),
        .i_resp_valid(1'b0), .i_resp_data(128'h0),
        .o_line_valid(d2LineValid), .o_line_data(d2LineData),
        .o_flush(d2Flush), .o_flush_word(d2FlushWord), .o_abort(d2Abort)
    );

    int total = 0;
    int bad = 0;

    int          mOcc, mOut, mDrop, pendingResp, dutLines;
    logic [31:0] mAddr;
    bit          mReqValid;
    bit          lastAccept, lastLineValid, lastFlush, lastAbort;
    logic [1:0]  lastFlushWord;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelReset();
        mOcc = 0;
        mOut = 0;
        mDrop = 0;
        mAddr = 32'h0040_0000;
        mReqValid = 1'b0;
        pendingResp = 0;
        dutLines = 0;
        lastAccept = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        redirValid = 1'b0;
        redirAddr = '0;
        linePop = 1'b0;
        reqReady = 1'b0;
        respValid = 1'b0;
        respData = '0;
        @(negedge clk);
        #1;
        checkOutput("rst_req_valid", 128'(reqValid), 128'(0));
        checkOutput("rst_req_addr", 128'(reqAddr), 128'(32'h0040_0000));
        checkOutput("rst_line_valid", 128'(lineValid), 128'(0));
        checkOutput("rst_flush", 128'(flush), 128'(0));
        checkOutput("rst_flush_word", 128'(flushWord), 128'(0));
        checkOutput("rst_abort", 128'(abortReq), 128'(0));
        checkOutput("rst_wrap_addr", 128'(d2ReqAddr), 128'(32'hFFFF_FFF0));
        rst = 1'b0;
        modelReset();
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] raddr, input bit pop,
                                 input bit rdy, input bit rv, input logic [127:0] rdata);
        bit accept, respOk, expLine;
        int newOut, live;
        redirValid = redir;
        redirAddr = raddr;
        linePop = pop;
        reqReady = rdy;
        respValid = rv;
        respData = rdata;
        #1;
        accept = mReqValid && rdy;
        respOk = rv && (mOut > 0);
        expLine = respOk && (mDrop == 0) && !redir;

        checkOutput("req_valid", 128'(reqValid), 128'(mReqValid));
        checkOutput("req_addr", 128'(reqAddr), 128'(mAddr));
        checkOutput("line_valid", 128'(lineValid), 128'(expLine));
        if (expLine) checkOutput("line_data", lineData, rdata);
        checkOutput("flush", 128'(flush), 128'(redir));
        checkOutput("flush_word", 128'(flushWord), 128'(redir ? raddr[3:2] : 2'b00));
        checkOutput("abort", 128'(abortReq), 128'(redir && mReqValid && !rdy));

        lastAccept = accept;
        lastLineValid = lineValid;
        lastFlush = flush;
        lastFlushWord = flushWord;
        lastAbort = abortReq;
        if (lineValid) dutLines++;

        if (accept) pendingResp++;
        if (rv && pendingResp > 0) pendingResp--;

        newOut = mOut + int'(accept) - int'(respOk);
        if (newOut > MO) newOut = MO;
        if (respOk && mDrop > 0) mDrop--;
        if (redir) begin
            mOcc = 0;
            mOut = newOut;
            mDrop = newOut;
            mAddr = {raddr[31:4], 4'h0};
            mReqValid = 1'b1;
        end else begin
            if (pop && mOcc > 0) mOcc--;
            if (expLine) mOcc++;
            if (mOcc > QL) mOcc = QL;
            if (accept) mAddr = mAddr + 32'd16;
            mOut = newOut;
            live = mOut - mDrop;
            mReqValid = ((QL - mOcc - live) > 0) && (mOut < MO);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset release and first two requests, plus wrap-around instance.
        resetDut();
        applyStimulus(0, '0, 0, 1, 0, '0);
        checkOutput("t1_first_valid", 128'(reqValid), 128'(1));
        checkOutput("t1_first_addr", 128'(reqAddr), 128'(32'h0040_0000));
        checkOutput("t6_wrap_first", 128'(d2ReqAddr), 128'(32'hFFFF_FFF0));
        applyStimulus(0, '0, 0, 1, 0, '0);
        checkOutput("t1_second_addr", 128'(reqAddr), 128'(32'h0040_0010));
        checkOutput("t6_wrap_second", 128'(d2ReqAddr), 128'(32'h0000_0000));
        applyStimulus(0, '0, 0, 1, 0, '0);
        checkOutput("t1_stall", 128'(reqValid), 128'(0));

        // Responses one cycle after each accept fill the queue, then a pop resumes.
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 1, lastAccept, randData());
        checkOutput("t2_lines", 128'(dutLines), 128'(4));
        checkOutput("t2_stalled", 128'(reqValid), 128'(0));
        applyStimulus(0, '0, 1, 0, 0, '0);
        checkOutput("t2_resume_valid", 128'(reqValid), 128'(1));
        checkOutput("t2_resume_addr", 128'(reqAddr), 128'(32'h0040_0040));

        // Redirect with two outstanding: stale responses dropped, new line forwarded.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 1, 0, '0);
        applyStimulus(1, 32'h0000_1238, 0, 1, 0, '0);
        checkOutput("t3_flush", 128'(lastFlush), 128'(1));
        checkOutput("t3_flush_word", 128'(lastFlushWord), 128'(2));
        checkOutput("t3_new_valid", 128'(reqValid), 128'(1));
        checkOutput("t3_new_addr", 128'(reqAddr), 128'(32'h0000_1230));
        applyStimulus(0, '0, 0, 0, 1, randData());
        checkOutput("t3_drop1", 128'(lastLineValid), 128'(0));
        applyStimulus(0, '0, 0, 1, 1, randData());
        checkOutput("t3_drop2", 128'(lastLineValid), 128'(0));
        applyStimulus(0, '0, 0, 0, 1, randData());
        checkOutput("t3_forward", 128'(lastLineValid), 128'(1));

        // Redirect coinciding with a response and a pop.
        resetDut();
        applyStimulus(0, '0, 0, 1, 0, '0);
        applyStimulus(0, '0, 0, 1, 0, '0);
        applyStimulus(0, '0, 0, 0, 1, randData());
        checkOutput("t4_pre_line", 128'(lastLineValid), 128'(1));
        applyStimulus(0, '0, 0, 1, 0, '0);
        applyStimulus(1, 32'h0000_8004, 1, 0, 1, randData());
        checkOutput("t4_line_blocked", 128'(lastLineValid), 128'(0));
        checkOutput("t4_flush_word", 128'(lastFlushWord), 128'(1));
        applyStimulus(0, '0, 0, 1, 0, '0);
        applyStimulus(0, '0, 0, 0, 1, randData());
        checkOutput("t4_after_forward", 128'(lastLineValid), 128'(1));

        // Cache not ready for three cycles, then redirect withdraws the request.
        resetDut();
        applyStimulus(0, '0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t5_hold_addr", 128'(reqAddr), 128'(32'h0040_0000));
            applyStimulus(0, '0, 0, 0, 0, '0);
        end
        applyStimulus(1, 32'h0000_2000, 0, 0, 0, '0);
        checkOutput("t5_abort", 128'(lastAbort), 128'(1));
        checkOutput("t5_new_addr", 128'(reqAddr), 128'(32'h0000_2000));

        // Randomized traffic against the reference model.
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            bit rdm, pp, rd, rv;
            rdm = ($urandom_range(0, 99) < 4);
            pp = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 70);
            rv = (pendingResp > 0) && ($urandom_range(0, 99) < 50);
            applyStimulus(rdm, $urandom & 32'hFFFF_FFFC, pp, rd, rv, randData());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
